// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: FSM states, tag layout, width helpers.
package matmul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StFin
  } state_e;

  // Tag layout: {elem_addr, last, first, valid}
  localparam int unsigned TagValid   = 0;
  localparam int unsigned TagFirst   = 1;
  localparam int unsigned TagLast    = 2;
  localparam int unsigned TagAddrLsb = 3;

  function automatic int unsigned addr_w(input int unsigned dim);
    return $clog2(dim * dim - 1) + 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned dim);
    return $clog2(dim) + 1;
  endfunction

  function automatic int unsigned tag_w(input int unsigned aw);
    return TagAddrLsb + aw;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control/address bundle between the host and the matrix-multiply sequencer.
interface matmul_sequencer_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr_m1;
  logic [ADDR_W-1:0] rd_addr_m2;
  logic              acc_en;
  logic              acc_load;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;

  // Host side: requests runs, observes status and datapath controls
  modport master (
    output start, abort,
    input  busy, done, rd_addr_m1, rd_addr_m2, acc_en, acc_load, out_we, out_addr
  );

  // Sequencer side
  modport slave (
    input  start, abort,
    output busy, done, rd_addr_m1, rd_addr_m2, acc_en, acc_load, out_we, out_addr
  );
endinterface

// File: rtl/mm_tag_pipe.sv
// Fixed-depth tag shift register mirroring the datapath latency; clr wipes every stage.
module mm_tag_pipe
  import matmul_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] tag_in,
  output logic [WIDTH-1:0] tag_out,
  output logic             empty
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one stage per cycle, or clear all stages
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < DEPTH; s++) stage_q[s] <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int s = 1; s < DEPTH; s++) stage_q[s] <= stage_q[s-1];
    end
  end

  assign tag_out = stage_q[DEPTH-1];

  // Empty when no stage carries a valid tag
  always_comb begin
    empty = 1'b1;
    for (int s = 0; s < DEPTH; s++) begin
      if (stage_q[s][TagValid]) empty = 1'b0;
    end
  end

endmodule

// File: rtl/matmul_sequencer.sv
// Run controller for the DIMxDIM complex matmul datapath: issues DIM^3 operand address
// pairs, then drives accumulate and output-write strobes aligned through a tag pipe.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned DIM      = 3,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned ADDR_W   = addr_w(DIM)
) (
  input  logic               clk,
  input  logic               rst,
  matmul_sequencer_if.slave  bus
);

  localparam int unsigned CW = cnt_w(DIM);
  localparam int unsigned TW = tag_w(ADDR_W);
  localparam logic [CW-1:0]     CntLast = CW'(DIM - 1);
  localparam logic [ADDR_W-1:0] DimA    = ADDR_W'(DIM);

  state_e state_q, state_d;
  logic [CW-1:0]     i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ADDR_W-1:0] m1_q, m1_d, m2_q, m2_d, row_q, row_d, elem_q, elem_d;
  logic              out_we_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [TW-1:0]     tag_in, tag_out;
  logic              pipe_empty;

  logic issue, k_wrap, j_wrap, last_issue, abort_hit, clr, fin_elem;

  assign issue      = (state_q == StIssue);
  assign k_wrap     = (k_q == CntLast);
  assign j_wrap     = (j_q == CntLast);
  assign last_issue = issue && k_wrap && j_wrap && (i_q == CntLast);
  assign abort_hit  = bus.abort && (state_q != StIdle);
  assign clr        = !rst || abort_hit;
  assign fin_elem   = tag_out[TagValid] && tag_out[TagLast];

  // State register
  always_ff @(posedge clk) begin
    if (clr) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: abort overrides any transition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: if (pipe_empty && out_we_q) state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_hit) state_d = StIdle;
  end

  // Loop counters and incremental addresses; m1 returns to the row base on a k wrap
  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    k_d    = k_q;
    m1_d   = m1_q;
    m2_d   = m2_q;
    row_d  = row_q;
    elem_d = elem_q;
    if (state_q == StIdle && bus.start) begin
      i_d    = '0;
      j_d    = '0;
      k_d    = '0;
      m1_d   = '0;
      m2_d   = '0;
      row_d  = '0;
      elem_d = '0;
    end else if (issue && !last_issue) begin
      if (!k_wrap) begin
        k_d  = k_q + CW'(1);
        m1_d = m1_q + ADDR_W'(1);
        m2_d = m2_q + DimA;
      end else begin
        k_d    = '0;
        elem_d = elem_q + ADDR_W'(1);
        if (!j_wrap) begin
          j_d  = j_q + CW'(1);
          m1_d = row_q;
          m2_d = ADDR_W'(j_q) + ADDR_W'(1);
        end else begin
          j_d   = '0;
          i_d   = i_q + CW'(1);
          m1_d  = m1_q + ADDR_W'(1);
          row_d = row_q + DimA;
          m2_d  = '0;
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (clr) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      m1_q   <= '0;
      m2_q   <= '0;
      row_q  <= '0;
      elem_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      k_q    <= k_d;
      m1_q   <= m1_d;
      m2_q   <= m2_d;
      row_q  <= row_d;
      elem_q <= elem_d;
    end
  end

  // Tag for the pair issued this cycle
  always_comb begin
    tag_in = '0;
    tag_in[TagValid] = issue;
    tag_in[TagFirst] = issue && (k_q == '0);
    tag_in[TagLast]  = issue && k_wrap;
    tag_in[TagAddrLsb +: ADDR_W] = issue ? elem_q : '0;
  end

  mm_tag_pipe #(
    .WIDTH (TW),
    .DEPTH (PIPE_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .clr     (clr),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .empty   (pipe_empty)
  );

  // Output write trails the final accumulate by one cycle so the accumulator settles
  always_ff @(posedge clk) begin
    if (clr) begin
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
    end else begin
      out_we_q   <= fin_elem;
      out_addr_q <= fin_elem ? tag_out[TagAddrLsb +: ADDR_W] : '0;
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StFin);
  assign bus.rd_addr_m1 = m1_q;
  assign bus.rd_addr_m2 = m2_q;
  assign bus.acc_en     = tag_out[TagValid];
  assign bus.acc_load   = tag_out[TagValid] && tag_out[TagFirst];
  assign bus.out_we     = out_we_q;
  assign bus.out_addr   = out_addr_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_matmul_sequencer;
  import matmul_pkg::*;

  localparam int unsigned AW0 = addr_w(3);
  localparam int unsigned AW1 = addr_w(1);

  typedef struct {
    int cyc;
    int dut;
    int a;
    int b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 1'b0;
  int   b;

  ev_t q_addr[$];
  ev_t q_acc[$];
  ev_t q_out[$];
  ev_t q_done[$];
  bit  busy0[int];
  bit  busy1[int];
  ev_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_sequencer_if #(.ADDR_W(AW0)) bus0 ();
  matmul_sequencer_if #(.ADDR_W(AW1)) bus1 ();

  matmul_sequencer #(.DIM(3), .PIPE_LAT(3), .ADDR_W(AW0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  matmul_sequencer #(.DIM(1), .PIPE_LAT(1), .ADDR_W(AW1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Expected events of one run, truncated at run-relative cycle 'limit'
  function automatic void push_run(input int dut, input int dim, input int lat, input int bs,
                                   input int limit);
    int n = 0;
    int dn = bs + dim * dim * dim + lat + 2;
    for (int i = 0; i < dim; i++) begin
      for (int j = 0; j < dim; j++) begin
        for (int k = 0; k < dim; k++) begin
          int c = bs + 1 + n;
          if (c - bs <= limit) q_addr.push_back('{c, dut, i * dim + k, k * dim + j});
          if (c + lat - bs <= limit) q_acc.push_back('{c + lat, dut, (k == 0) ? 1 : 0, 0});
          if (k == dim - 1 && c + lat + 1 - bs <= limit)
            q_out.push_back('{c + lat + 1, dut, i * dim + j, 0});
          n++;
        end
      end
    end
    if (dn - bs <= limit) q_done.push_back('{dn, dut, 0, 0});
    for (int c = bs + 1; c <= dn && c - bs <= limit; c++) begin
      if (dut == 0) busy0[c] = 1'b1;
      else          busy1[c] = 1'b1;
    end
  endfunction

  // Pop the oldest expected event of one kind and compare against what the DUT shows
  function automatic void take(input int kind, input int dut, input int val);
    ev_t e;
    bit have = 1'b0;
    string nm;
    case (kind)
      0: begin nm = "acc";  if (q_acc.size()  > 0) begin e = q_acc.pop_front();  have = 1; end end
      1: begin nm = "out";  if (q_out.size()  > 0) begin e = q_out.pop_front();  have = 1; end end
      default: begin
        nm = "done";
        if (q_done.size() > 0) begin e = q_done.pop_front(); have = 1; end
      end
    endcase
    if (!have) begin
      check({nm, "_unexpected"}, dut, -1);
    end else begin
      check({nm, "_cycle"}, cyc, e.cyc);
      check({nm, "_dut"}, dut, e.dut);
      if (kind != 2) check({nm, "_value"}, val, e.a);
    end
  endfunction

  // Monitor: compare DUT outputs against the scoreboard once per cycle
  always @(negedge clk) begin
    if (mon_on) begin
      check("busy0", int'(bus0.busy), busy0.exists(cyc) ? 1 : 0);
      check("busy1", int'(bus1.busy), busy1.exists(cyc) ? 1 : 0);
      while (q_addr.size() > 0 && q_addr[0].cyc <= cyc) begin
        mon_e = q_addr.pop_front();
        check("addr_cycle", cyc, mon_e.cyc);
        if (mon_e.dut == 0) begin
          check("rd_addr_m1", int'(bus0.rd_addr_m1), mon_e.a);
          check("rd_addr_m2", int'(bus0.rd_addr_m2), mon_e.b);
        end else begin
          check("rd_addr_m1_d1", int'(bus1.rd_addr_m1), mon_e.a);
          check("rd_addr_m2_d1", int'(bus1.rd_addr_m2), mon_e.b);
        end
      end
      if (bus0.acc_en) take(0, 0, int'(bus0.acc_load));
      if (bus1.acc_en) take(0, 1, int'(bus1.acc_load));
      if (bus0.out_we) take(1, 0, int'(bus0.out_addr));
      else check("out_addr_idle0", int'(bus0.out_addr), 0);
      if (bus1.out_we) take(1, 1, int'(bus1.out_addr));
      else check("out_addr_idle1", int'(bus1.out_addr), 0);
      if (bus0.done) take(2, 0, 0);
      if (bus1.done) take(2, 1, 0);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse start (optionally with abort) in run cycle 0 and record the base cycle
  task automatic launch(input int dut, input int dim, input int lat, input int limit,
                        input bit with_abort, output int bs);
    @(posedge clk);
    #1;
    bs = cyc;
    push_run(dut, dim, lat, bs, limit);
    if (dut == 0) begin bus0.start = 1'b1; bus0.abort = with_abort; end
    else          begin bus1.start = 1'b1; bus1.abort = with_abort; end
    @(posedge clk);
    #1;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     int'(bus0.busy), 0);
    check({tag, "_done"},     int'(bus0.done), 0);
    check({tag, "_acc_en"},   int'(bus0.acc_en), 0);
    check({tag, "_acc_load"}, int'(bus0.acc_load), 0);
    check({tag, "_out_we"},   int'(bus0.out_we), 0);
    check({tag, "_out_addr"}, int'(bus0.out_addr), 0);
    check({tag, "_m1"},       int'(bus0.rd_addr_m1), 0);
    check({tag, "_m2"},       int'(bus0.rd_addr_m2), 0);
  endtask

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    mon_on = 1'b1;

    // Full DIM=3 run: addresses, acc_load, out writes, done, busy window
    launch(0, 3, 3, 1000, 1'b0, b);
    wait_to(b + 40);

    // start held for 40 cycles: second run begins once IDLE samples start in cycle 33
    @(posedge clk);
    #1;
    b = cyc;
    push_run(0, 3, 3, b, 1000);
    push_run(0, 3, 3, b + 33, 1000);
    bus0.start = 1'b1;
    wait_to(b + 40);
    bus0.start = 1'b0;
    wait_to(b + 75);

    // abort in cycle 12, then a relaunch with abort also high in IDLE
    launch(0, 3, 3, 12, 1'b0, b);
    wait_to(b + 12);
    bus0.abort = 1'b1;
    @(posedge clk);
    #1;
    bus0.abort = 1'b0;
    wait_to(b + 20);
    launch(0, 3, 3, 1000, 1'b1, b);
    wait_to(b + 40);

    // Reset in cycle 20 mid-run
    launch(0, 3, 3, 20, 1'b0, b);
    wait_to(b + 20);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst = 1'b1;
    wait_to(b + 25);
    launch(0, 3, 3, 1000, 1'b0, b);
    wait_to(b + 40);

    // DIM=1, PIPE_LAT=1 instance
    launch(1, 1, 1, 1000, 1'b0, b);
    wait_to(b + 10);

    check("pending_addr", q_addr.size(), 0);
    check("pending_acc",  q_acc.size(),  0);
    check("pending_out",  q_out.size(),  0);
    check("pending_done", q_done.size(), 0);
    mon_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
